// File: rtl/ss_rr_arbiter.sv
// ss_rr_arbiter: packet-granular round-robin N:1 stream arbiter with a registered output stage
module ss_rr_arbiter #(
   parameter int NUM_IN = 4,
   parameter int NUM_BYTES = 8,
   parameter int USER_BITS = 2,
   parameter int ID_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_IN-1:0]              s_valid,
   output logic [NUM_IN-1:0]              s_ready,
   input  logic [NUM_IN*8*NUM_BYTES-1:0]  s_data,
   input  logic [NUM_IN*NUM_BYTES-1:0]    s_keep,
   input  logic [NUM_IN-1:0]              s_last,
   input  logic [NUM_IN*USER_BITS-1:0]    s_user,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [8*NUM_BYTES-1:0]         m_data,
   output logic [NUM_BYTES-1:0]           m_keep,
   output logic                           m_last,
   output logic [USER_BITS-1:0]           m_user,
   output logic [ID_W-1:0]                m_id
);
   localparam int DW = 8 * NUM_BYTES;
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d, lock_q, lock_d, sel, sel_inc;
   logic [ID_W:0] idx;
   logic found, elig, load, accept;
   logic m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic [NUM_BYTES-1:0] m_keep_q, m_keep_d;
   logic [USER_BITS-1:0] m_user_q, m_user_d;
   logic [ID_W-1:0] m_id_q, m_id_d;
   // Grant the locked input mid-packet, otherwise the first valid input at or after ptr
   always_comb begin
      found = 1'b0;
      sel = (state_q == LOCKED) ? lock_q : ptr_q;
      idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_IN)) idx = idx - (ID_W+1)'(NUM_IN);
         if (state_q == IDLE && !found && s_valid[idx[ID_W-1:0]]) begin
            found = 1'b1;
            sel = idx[ID_W-1:0];
         end
      end
   end
   assign elig = (state_q == LOCKED) || found;
   assign load = !m_valid_q || m_ready;
   assign accept = elig && load && s_valid[sel];
   assign s_ready = (!rst && elig && load) ? (NUM_IN'(1) << sel) : '0;
   assign sel_inc = (sel == ID_W'(NUM_IN - 1)) ? '0 : sel + 1'b1;
   // Load the output slot from the granted input and advance lock/pointer at packet ends
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d = m_data_q;
      m_keep_d = m_keep_q;
      m_last_d = m_last_q;
      m_user_d = m_user_q;
      m_id_d = m_id_q;
      state_d = state_q;
      ptr_d = ptr_q;
      lock_d = lock_q;
      if (accept) begin
         m_valid_d = 1'b1;
         m_last_d = s_last[sel];
         m_id_d = sel;
         for (int i = 0; i < NUM_IN; i++) begin
            if (sel == ID_W'(i)) begin
               m_data_d = s_data[i*DW +: DW];
               m_keep_d = s_keep[i*NUM_BYTES +: NUM_BYTES];
               m_user_d = s_user[i*USER_BITS +: USER_BITS];
            end
         end
         if (s_last[sel]) begin
            state_d = IDLE;
            ptr_d = sel_inc;
         end else begin
            state_d = LOCKED;
            lock_d = sel;
         end
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end
   // State and output registers; reset discards any partial packet
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         lock_q <= '0;
         m_valid_q <= 1'b0;
         m_data_q <= '0;
         m_keep_q <= '0;
         m_last_q <= 1'b0;
         m_user_q <= '0;
         m_id_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         lock_q <= lock_d;
         m_valid_q <= m_valid_d;
         m_data_q <= m_data_d;
         m_keep_q <= m_keep_d;
         m_last_q <= m_last_d;
         m_user_q <= m_user_d;
         m_id_q <= m_id_d;
      end
   end
   assign m_valid = m_valid_q;
   assign m_data = m_data_q;
   assign m_keep = m_keep_q;
   assign m_last = m_last_q;
   assign m_user = m_user_q;
   assign m_id = m_id_q;
endmodule

// File: tb/tb_ss_rr_arbiter.sv
// tb_ss_rr_arbiter: randomized scoreboard bench for the round-robin packet arbiter
module tb_ss_rr_arbiter;
   localparam int N = 4, NB = 8, UB = 2, IW = 2, DW = 64;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [N-1:0] s_valid = '0, s_ready, s_last = '0;
   logic [N*DW-1:0] s_data = '0;
   logic [N*NB-1:0] s_keep = '0;
   logic [N*UB-1:0] s_user = '0;
   logic m_valid, m_ready = 1'b0, m_last;
   logic [DW-1:0] m_data;
   logic [NB-1:0] m_keep;
   logic [UB-1:0] m_user;
   logic [IW-1:0] m_id;
   ss_rr_arbiter #(.NUM_IN(N), .NUM_BYTES(NB), .USER_BITS(UB)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .s_user(s_user), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_user(m_user), .m_id(m_id));
   logic [2:0] v3 = '0, r3, l3 = 3'b111, k3 = '0, u3 = '0;
   logic [23:0] d3 = 24'h332211;
   logic mv3, ml3, mk3, mu3, rdy3 = 1'b1;
   logic [7:0] md3;
   logic [1:0] mi3;
   ss_rr_arbiter #(.NUM_IN(3), .NUM_BYTES(1), .USER_BITS(1)) dut3 (
      .clk(clk), .rst(rst), .s_valid(v3), .s_ready(r3), .s_data(d3), .s_keep(k3), .s_last(l3),
      .s_user(u3), .m_valid(mv3), .m_ready(rdy3), .m_data(md3), .m_keep(mk3), .m_last(ml3),
      .m_user(mu3), .m_id(mi3));
   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [NB-1:0] keep;
      logic last;
      logic [UB-1:0] user;
   } beat_t;
   beat_t sb[$];
   beat_t mon_e;
   int ids[$];
   int n_tests = 0, n_fail = 0, gaps = 0, n_in = 0;
   bit chk_en = 1'b0;
   int pk_left[N], beat_left[N];
   int gap_pct = 0, rdy_pct = 100, minlen = 1, maxlen = 1;
   logic [N-1:0] acc = '0;
   bit mlocked, mv;
   int mptr, mlock;
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic model_reset();
      mlocked = 1'b0; mv = 1'b0; mptr = 0; mlock = 0;
      for (int i = 0; i < N; i++) begin pk_left[i] = 0; beat_left[i] = 0; end
      acc = '0;
   endtask
   // One clock of stimulus: retire accepted beats, present new ones, check grants against the model
   task automatic step();
      int w;
      logic [N-1:0] exp_rdy;
      bit ld;
      beat_t b;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (acc[i]) s_valid[i] = 1'b0;
      m_ready = ($urandom_range(99) < rdy_pct);
      for (int i = 0; i < N; i++)
         if (!s_valid[i] && pk_left[i] > 0 && $urandom_range(99) >= gap_pct) begin
            if (beat_left[i] == 0) beat_left[i] = $urandom_range(maxlen, minlen);
            s_valid[i] = 1'b1;
            s_data[i*DW +: DW] = {$urandom, $urandom};
            s_keep[i*NB +: NB] = NB'($urandom);
            s_last[i] = (beat_left[i] == 1);
            s_user[i*UB +: UB] = UB'($urandom);
         end
      #1;
      w = -1;
      if (mlocked) w = mlock;
      else for (int k = 0; k < N; k++) if (w < 0 && s_valid[(mptr + k) % N]) w = (mptr + k) % N;
      ld = !mv || m_ready;
      exp_rdy = (w >= 0 && ld) ? (N'(1) << w) : '0;
      check("s_ready", s_ready, exp_rdy);
      if (w >= 0 && ld && s_valid[w]) begin
         mv = 1'b1;
         if (s_last[w]) begin mlocked = 1'b0; mptr = (w + 1) % N; end
         else begin mlocked = 1'b1; mlock = w; end
      end else if (m_ready) mv = 1'b0;
      if (|s_valid && !(|(s_valid & s_ready))) gaps++;
      acc = s_valid & s_ready;
      for (int i = 0; i < N; i++) if (acc[i]) begin
         b.id = IW'(i);
         b.data = s_data[i*DW +: DW];
         b.keep = s_keep[i*NB +: NB];
         b.last = s_last[i];
         b.user = s_user[i*UB +: UB];
         sb.push_back(b);
         n_in++;
         beat_left[i]--;
         if (beat_left[i] == 0) pk_left[i]--;
      end
   endtask
   task automatic run(input int maxcyc);
      bit done;
      done = 1'b0;
      for (int c = 0; c < maxcyc && !done; c++) begin
         step();
         done = (s_valid == '0) && (sb.size() == 0);
         for (int i = 0; i < N; i++) if (pk_left[i] != 0) done = 1'b0;
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: traffic still pending after %0d cycles, required drained", maxcyc);
      end
   endtask
   task automatic check_ids(input string name, input int exp[$]);
      check({name, "_count"}, ids.size(), exp.size());
      for (int k = 0; k < exp.size() && k < ids.size(); k++) check(name, ids[k], exp[k]);
   endtask
   // Scoreboard monitor: the presented beat must match the oldest accepted input beat until it drains
   always @(negedge clk) begin
      if (chk_en && !rst && m_valid) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: got id %0d data %0h, required no beat", m_id, m_data);
         end else begin
            mon_e = sb[0];
            check("beat", {m_id, m_data, m_keep, m_last, m_user}, mon_e);
            if (m_ready) begin
               ids.push_back(int'(m_id));
               void'(sb.pop_front());
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int exp_ids[$];
      int fair_ids[$];
      model_reset();
      repeat (2) @(posedge clk);
      #1 s_valid = 4'b0001;
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_id", m_id, 0);
      check("rst_m_last", m_last, 0);
      check("rst_s_ready", s_ready, 0);
      s_valid = '0;
      @(posedge clk); #1 rst = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < N; i++) pk_left[i] = 8;
      gaps = 0; ids = {};
      run(200);
      check("fair_gaps", gaps, 0);
      for (int k = 0; k < 32; k++) fair_ids.push_back(k % 4);
      check_ids("fair_order", fair_ids);
      ids = {}; gaps = 0;
      minlen = 3; maxlen = 3; pk_left[2] = 1;
      run(50);
      check("single_gaps", gaps, 0);
      minlen = 1; maxlen = 1; pk_left[0] = 1; pk_left[3] = 1;
      run(50);
      exp_ids = {2, 2, 2, 3, 0};
      check_ids("single_then_wrap", exp_ids);
      ids = {};
      minlen = 4; maxlen = 4; pk_left[0] = 1;
      step();
      gap_pct = 40; minlen = 2; maxlen = 2; pk_left[1] = 1;
      run(200);
      exp_ids = {0, 0, 0, 0, 1, 1};
      check_ids("lock_order", exp_ids);
      ids = {}; n_in = 0;
      gap_pct = 30; rdy_pct = 50; minlen = 1; maxlen = 5;
      pk_left[0] = 7; pk_left[1] = 7; pk_left[3] = 6;
      run(3000);
      check("bp_beat_count", ids.size(), n_in);
      chk_en = 1'b0;
      @(posedge clk); #1 v3 = 3'b010;
      #1 check("n3_first", r3, 3'b010);
      @(posedge clk); #1 v3 = 3'b101;
      #1 check("n3_ptr2_wins", r3, 3'b100);
      @(posedge clk); #1 check("n3_id2", mi3, 2);
      v3 = 3'b001;
      #1 check("n3_wrap_to0", r3, 3'b001);
      @(posedge clk); #1 check("n3_id0", mi3, 0);
      v3 = 3'b110;
      #1 check("n3_ptr1", r3, 3'b010);
      @(posedge clk); #1 check("n3_id1", mi3, 1);
      v3 = '0;
      @(posedge clk); #1;
      m_ready = 1'b1; s_last = '0; s_valid = 4'b0010;
      s_data[DW +: DW] = 64'hA1A1_0000_0000_0001;
      @(posedge clk); #1 s_data[DW +: DW] = 64'hA2A2_0000_0000_0002;
      @(posedge clk); #1;
      check("rstpkt_beat2", m_data, 64'hA2A2_0000_0000_0002);
      s_data[DW +: DW] = 64'hA3A3_0000_0000_0003;
      @(negedge clk); rst = 1'b1;
      #1;
      check("rstpkt_m_valid", m_valid, 0);
      check("rstpkt_s_ready", s_ready, 0);
      check("rstpkt_m_data", m_data, 0);
      @(posedge clk); #1;
      s_valid = 4'b1000; s_last = 4'b1000;
      s_data[3*DW +: DW] = 64'hB3B3_B3B3_0000_0033;
      rst = 1'b0;
      #1 check("rstpkt_grant3", s_ready, 4'b1000);
      @(posedge clk); #1;
      s_valid = '0;
      check("rstpkt_m_valid3", m_valid, 1);
      check("rstpkt_m_id3", m_id, 3);
      check("rstpkt_m_data3", m_data, 64'hB3B3_B3B3_0000_0033);
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ss_rr_arbiter.md
Name: ss_rr_arbiter

Overview:
- N-input to 1-output stream arbiter for the ss valid/ready stream (data/keep/last/user).
- Round-robin arbitration at packet granularity: a grant is held from the first accepted beat until the beat with last=1 is accepted. Packets never interleave.
- Output is registered, with one register stage equivalent to a register slice, so it drops directly in front of shared downstream consumers (DMA, egress port).

Parameters:
- NUM_IN, 4, number of input streams (2..16).
- NUM_BYTES, 8, data bytes per beat; data width 8*NUM_BYTES, keep width NUM_BYTES.
- USER_BITS, 2, sideband user width (>=1).
- ID_W, $clog2(NUM_IN) (min 1), width of the source-index output.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  NUM_IN  per-input valid.
- s_ready  out  NUM_IN  per-input ready.
- s_data  in  NUM_IN*8*NUM_BYTES  packed input data; input i occupies slice i.
- s_keep  in  NUM_IN*NUM_BYTES  packed byte enables.
- s_last  in  NUM_IN  end-of-packet flags.
- s_user  in  NUM_IN*USER_BITS  packed user sideband.
- m_valid  out  1  output valid (registered).
- m_ready  in  1  downstream ready.
- m_data  out  8*NUM_BYTES  registered data.
- m_keep  out  NUM_BYTES  registered keep.
- m_last  out  1  registered last.
- m_user  out  USER_BITS  registered user.
- m_id  out  ID_W  index of the input that produced the current output beat.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, lock_idx=0. All m_* outputs are 0 and s_ready is all 0.
- Output register:
  - load = (!m_valid || m_ready).
  - sel_valid = s_valid[sel].
  - accept = sel_valid && load.
  - On accept: m_valid<=1 and m_data/keep/last/user/id<=input sel.
  - Else if m_ready: m_valid<=0.
  - Else hold. m_* stay stable while m_valid && !m_ready.
- s_ready[i] = load && (i==sel) && state-eligible. At most one bit is set; it is combinational from m_ready, m_valid and s_valid.
- Latency 1 cycle; full throughput (1 beat/cycle) under continuous m_ready.
- State machine:
  - IDLE:
    - sel = first i with s_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_IN.
    - No valid input: no grant, s_ready=0.
    - accept with last=0: go to LOCKED with lock_idx=sel.
    - accept with last=1 (single-beat packet): stay IDLE with ptr<=(sel+1) mod NUM_IN.
  - LOCKED:
    - sel=lock_idx regardless of other valids.
    - Lock holds while the locked input deasserts valid mid-packet; other inputs are blocked.
    - accept with last=1: go to IDLE with ptr<=(lock_idx+1) mod NUM_IN.
- Wrap: ptr at NUM_IN-1 advances to 0. Non-power-of-two NUM_IN uses an explicit compare, never a bit truncation.
- Simultaneous requests in IDLE: the input closest at/after ptr wins. The winner moves to lowest priority after its packet ends.
- Reset mid-packet: lock and pointer clear immediately, m_valid drops to 0, and partial packet state is discarded. The upstream is responsible for re-framing.
- No combinational path from s_valid to m_valid. The only combinational paths are m_ready/s_valid -> s_ready.

Test Plan:
- Single requester: NUM_IN=4, input 2 sends a 3-beat packet with m_ready=1 -> m_valid is high for 3 consecutive cycles starting 1 cycle after the first beat, m_id=2 on all beats, m_last on beat 3, ptr=3 afterwards.
- Fairness: all 4 inputs continuously offer 1-beat packets from reset -> m_id sequence is 0,1,2,3,0,1,... with no gaps.
- Packet lock: input 0 sends a 4-beat packet and input 1 raises valid during beat 2; input 0 idles 2 cycles mid-packet -> s_ready[1]=0 until input 0's last beat is accepted, then input 1's packet follows. The beats are never interleaved.
- Backpressure: random m_ready (50%) with 20 packets from 3 inputs -> m_* is stable whenever m_valid && !m_ready. The scoreboard sees every input's beats in order and unmodified, and every beat carries the correct m_id.
- Wrap and non-power-of-two: NUM_IN=3, ptr=2, inputs 0 and 2 valid -> input 2 wins, then input 0, then ptr=1.
- Reset mid-packet: assert rst during beat 2 of a 5-beat packet from input 1 -> m_valid=0, s_ready=0 and m_data=0 immediately, with no clock edge required. After release, input 3 alone is valid and is granted (IDLE, ptr=0 search).
